ysyx_25040111_memarb: RTL and testbench
=======================================

# ysyx_25040111_memarb

Two-master arbiter sharing the single downstream burst-read/write memory port between the instruction-cache refill engine (master I) and the load/store unit (master D). It latches one-cycle start pulses from either master, grants the port to one master for the full duration of its transaction, and forwards beats and completions back only to the owner. When both masters want the port it alternates between them round-robin. It sits between the icache/LSU and the bus bridge.

## Interface
- `IDLE_RR`, default 1: initial `last` owner after reset; 1 = D, so I wins the first tie.
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-low; sampled on `clock`.
- `i_rstart`  in  1  I beat request pulse.
- `i_raddr`  in  32  I beat address.
- `i_rlen`  in  8  I burst length minus 1.
- `i_rok`  out  1  I beat done; `m_ok` gated by I ownership.
- `i_rdata`  out  32  I read data; `m_rdata` passthrough.
- `d_start`  in  1  D request pulse, single beat.
- `d_wen`  in  1  D write when 1, read when 0.
- `d_addr`  in  32  D address.
- `d_wdata`  in  32  D write data.
- `d_wmask`  in  4  D byte strobes.
- `d_ok`  out  1  D done; `m_ok` gated by D ownership.
- `d_rdata`  out  32  D read data; `m_rdata` passthrough.
- `m_start`  out  1  registered downstream beat request pulse.
- `m_wen`  out  1  registered downstream write flag.
- `m_addr`  out  32  registered downstream address.
- `m_len`  out  8  registered downstream length; 0 for D.
- `m_wdata`  out  32  registered downstream write data.
- `m_wmask`  out  4  registered downstream byte strobes.
- `m_ok`  in  1  downstream beat complete.
- `m_rdata`  in  32  downstream read data, valid with `m_ok`.

## Operation
- **States:** IDLE, OWN_I, OWN_D. Reset (`reset`=0) sets state IDLE, `i_pend`=0, `d_pend`=0, `cnt`=0, `last`=`IDLE_RR`, and `m_start`/`m_wen`/`m_addr`/`m_len`/`m_wdata`/`m_wmask` all to 0.
- **Pending capture:** `i_rstart` outside OWN_I sets `i_pend` and captures `i_raddr`/`i_rlen`. `d_start` outside OWN_D sets `d_pend` and captures addr/wdata/wmask/wen.
  - A start pulse while its own pend is already set is ignored.
  - Masters do not re-issue before completion.
- **Launch condition:** a launch happens from IDLE, or on the cycle the final `m_ok` of the current owner arrives.
- **Launch candidates** are (a) a pending request, or (b) a start pulse arriving on that same cycle.
- **Winner selection:**
  - If only one candidate exists, it wins.
  - If both exist, the master that is not `last` wins.
  - The loser stays (or becomes) pending.
- **On launch:** `m_start`=1 for exactly one cycle; the m_* fields are loaded from the winner; `last` is set to the winner; the winner's pend is cleared; `cnt`=0.
  - I launch: `m_len`=`i_rlen`, `m_wen`=0, `m_wdata`=0, `m_wmask`=0.
  - D launch: `m_len`=0.
- **OWN_I, further beats:**
  - Each `i_rstart` produces `m_start`=1 the next cycle, with `m_addr`=`i_raddr`.
  - Each `m_ok` increments `cnt`.
  - The final beat is the one where `m_ok` arrives with `cnt`==`m_len`.
- **OWN_D:** the first `m_ok` is final.
- **Completion:** on the final `m_ok`, go to the next winner's OWN state if any candidate exists, else to IDLE.
- **Gating:** `i_rok` = `m_ok` & (state==OWN_I); `d_ok` = `m_ok` & (state==OWN_D). `m_ok` in IDLE is dropped.
- **Counter:** `cnt` is 8 bit; it never wraps because `m_len` ≤ 255.

## Timing
- Start to `m_start` latency is 1 cycle when the port is idle.
- Owner handover is zero-bubble: the next `m_start` is asserted the cycle after the final `m_ok`.
- `i_rok`/`d_ok`/`*_rdata` are combinational from `m_ok`/`m_rdata`, with 0 cycles added.
- `m_start` is never high for two consecutive cycles from a single request.
- `m_*` fields hold their value until the next launch or beat.
- **Reset mid-transaction:** ownership is lost and pends are cleared; the downstream port is expected to be reset in the same cycle.

## Test plan
- **Lone I burst:** `i_rstart`, `i_raddr`=0x8000_0040, `i_rlen`=3 in IDLE.
  - Required: next cycle `m_start`=1, `m_addr`=0x8000_0040, `m_len`=3.
  - Four `m_ok` pulses produce four `i_rok` pulses and no `d_ok`.
  - State is IDLE after the 4th.
- **Lone D write:** `d_start`, `d_wen`=1, addr 0xA000_03F8, wdata 0x12345678, wmask 0xF.
  - Required: next cycle the m_* fields equal those values with `m_len`=0.
  - One `m_ok` gives `d_ok`=1.
- **Simultaneous starts after reset:** `i_rstart` and `d_start` on the same cycle.
  - Required: I is granted first; D stays pending.
  - D's `m_start` appears the cycle after I's 4th `m_ok`.
  - Repeating the tie grants D first.
- **D request during an I burst** (arrives at beat 2 of 4):
  - Required: `d_ok` is never asserted before I finishes.
  - D's launch carries the captured values even if `d_addr` has since changed.
- **Reset mid-burst:** `reset`=0 for one cycle at beat 1 of 4 with D pending.
  - Required: all outputs 0 and state IDLE; the pending D is dropped.
  - A later stray `m_ok` produces no `i_rok`/`d_ok`.

Source files
------------

// File: rtl/ysyx_25040111_memarb.sv
// Two-master round-robin arbiter sharing one burst read/write memory port
// between the icache refill engine (I) and the load/store unit (D).
module ysyx_25040111_memarb #(
   parameter bit IDLE_RR = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        i_rstart,
   input  logic [31:0] i_raddr,
   input  logic [7:0]  i_rlen,
   output logic        i_rok,
   output logic [31:0] i_rdata,
   input  logic        d_start,
   input  logic        d_wen,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_wmask,
   output logic        d_ok,
   output logic [31:0] d_rdata,
   output logic        m_start,
   output logic        m_wen,
   output logic [31:0] m_addr,
   output logic [7:0]  m_len,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_wmask,
   input  logic        m_ok,
   input  logic [31:0] m_rdata
);

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned LW = 8;
   localparam int unsigned SW = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_I = 2'd1,
      OWN_D = 2'd2
   } state_t;

   state_t          state_q, state_n;
   logic            i_pend_q, i_pend_n;
   logic [AW-1:0]   i_addr_q, i_addr_n;
   logic [LW-1:0]   i_len_q, i_len_n;
   logic            d_pend_q, d_pend_n;
   logic            d_wen_q, d_wen_n;
   logic [AW-1:0]   d_addr_q, d_addr_n;
   logic [DW-1:0]   d_wdata_q, d_wdata_n;
   logic [SW-1:0]   d_wmask_q, d_wmask_n;
   logic [LW-1:0]   cnt_q, cnt_n;
   logic            last_q, last_n;

   logic            m_start_n, m_wen_n;
   logic [AW-1:0]   m_addr_n;
   logic [LW-1:0]   m_len_n;
   logic [DW-1:0]   m_wdata_n;
   logic [SW-1:0]   m_wmask_n;

   logic            fin, launch, i_cand, d_cand, pick_i, pick_d;
   logic [AW-1:0]   i_src_addr, d_src_addr;
   logic [LW-1:0]   i_src_len;
   logic [DW-1:0]   d_src_wdata;
   logic [SW-1:0]   d_src_wmask;
   logic            d_src_wen;

   // State and registered downstream request fields
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q   <= IDLE;
         i_pend_q  <= 1'b0;
         i_addr_q  <= '0;
         i_len_q   <= '0;
         d_pend_q  <= 1'b0;
         d_wen_q   <= 1'b0;
         d_addr_q  <= '0;
         d_wdata_q <= '0;
         d_wmask_q <= '0;
         cnt_q     <= '0;
         last_q    <= IDLE_RR;
         m_start   <= 1'b0;
         m_wen     <= 1'b0;
         m_addr    <= '0;
         m_len     <= '0;
         m_wdata   <= '0;
         m_wmask   <= '0;
      end else begin
         state_q   <= state_n;
         i_pend_q  <= i_pend_n;
         i_addr_q  <= i_addr_n;
         i_len_q   <= i_len_n;
         d_pend_q  <= d_pend_n;
         d_wen_q   <= d_wen_n;
         d_addr_q  <= d_addr_n;
         d_wdata_q <= d_wdata_n;
         d_wmask_q <= d_wmask_n;
         cnt_q     <= cnt_n;
         last_q    <= last_n;
         m_start   <= m_start_n;
         m_wen     <= m_wen_n;
         m_addr    <= m_addr_n;
         m_len     <= m_len_n;
         m_wdata   <= m_wdata_n;
         m_wmask   <= m_wmask_n;
      end
   end

   // Next-state, capture, arbitration and launch
   always_comb begin
      state_n   = state_q;
      i_pend_n  = i_pend_q;
      i_addr_n  = i_addr_q;
      i_len_n   = i_len_q;
      d_pend_n  = d_pend_q;
      d_wen_n   = d_wen_q;
      d_addr_n  = d_addr_q;
      d_wdata_n = d_wdata_q;
      d_wmask_n = d_wmask_q;
      cnt_n     = cnt_q;
      last_n    = last_q;
      m_start_n = 1'b0;
      m_wen_n   = m_wen;
      m_addr_n  = m_addr;
      m_len_n   = m_len;
      m_wdata_n = m_wdata;
      m_wmask_n = m_wmask;

      case (state_q)
         OWN_I:   fin = m_ok && (cnt_q == m_len);
         OWN_D:   fin = m_ok;
         default: fin = 1'b0;
      endcase
      launch = (state_q == IDLE) || fin;

      i_cand = i_pend_q || i_rstart;
      d_cand = d_pend_q || d_start;
      // last_q == 1 means D owned the port most recently, so I wins a tie
      pick_i = i_cand && (!d_cand || last_q);
      pick_d = d_cand && !pick_i;

      i_src_addr  = i_pend_q ? i_addr_q  : i_raddr;
      i_src_len   = i_pend_q ? i_len_q   : i_rlen;
      d_src_addr  = d_pend_q ? d_addr_q  : d_addr;
      d_src_wdata = d_pend_q ? d_wdata_q : d_wdata;
      d_src_wmask = d_pend_q ? d_wmask_q : d_wmask;
      d_src_wen   = d_pend_q ? d_wen_q   : d_wen;

      // Inside a live I burst, i_rstart is a beat request, not a new transaction
      if (i_rstart && !i_pend_q && ((state_q != OWN_I) || fin)) begin
         i_pend_n = 1'b1;
         i_addr_n = i_raddr;
         i_len_n  = i_rlen;
      end
      if (d_start && !d_pend_q && ((state_q != OWN_D) || fin)) begin
         d_pend_n  = 1'b1;
         d_wen_n   = d_wen;
         d_addr_n  = d_addr;
         d_wdata_n = d_wdata;
         d_wmask_n = d_wmask;
      end

      if (launch) begin
         if (pick_i) begin
            state_n   = OWN_I;
            i_pend_n  = 1'b0;
            last_n    = 1'b0;
            cnt_n     = '0;
            m_start_n = 1'b1;
            m_wen_n   = 1'b0;
            m_addr_n  = i_src_addr;
            m_len_n   = i_src_len;
            m_wdata_n = '0;
            m_wmask_n = '0;
         end else if (pick_d) begin
            state_n   = OWN_D;
            d_pend_n  = 1'b0;
            last_n    = 1'b1;
            cnt_n     = '0;
            m_start_n = 1'b1;
            m_wen_n   = d_src_wen;
            m_addr_n  = d_src_addr;
            m_len_n   = '0;
            m_wdata_n = d_src_wdata;
            m_wmask_n = d_src_wmask;
         end else begin
            state_n = IDLE;
         end
      end else if (state_q == OWN_I) begin
         if (m_ok) begin
            cnt_n = cnt_q + LW'(1);
         end
         if (i_rstart) begin
            m_start_n = 1'b1;
            m_addr_n  = i_raddr;
         end
      end
   end

   // Completions go back only to the current owner
   assign i_rok   = m_ok && (state_q == OWN_I);
   assign d_ok    = m_ok && (state_q == OWN_D);
   assign i_rdata = m_rdata;
   assign d_rdata = m_rdata;

endmodule

// File: tb/tb_ysyx_25040111_memarb.sv
// Directed bench for ysyx_25040111_memarb with a downstream-request scoreboard.
module tb_ysyx_25040111_memarb;

   typedef struct packed {
      logic        wen;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [31:0] wdata;
      logic [3:0]  wmask;
   } txn_t;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        i_rstart = 1'b0;
   logic [31:0] i_raddr = '0;
   logic [7:0]  i_rlen = '0;
   logic        i_rok;
   logic [31:0] i_rdata;
   logic        d_start = 1'b0;
   logic        d_wen = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic [3:0]  d_wmask = '0;
   logic        d_ok;
   logic [31:0] d_rdata;
   logic        m_start, m_wen;
   logic [31:0] m_addr, m_wdata;
   logic [7:0]  m_len;
   logic [3:0]  m_wmask;
   logic        m_ok = 1'b0;
   logic [31:0] m_rdata = '0;

   int   n_vec = 0;
   int   n_err = 0;
   txn_t q_i[$];
   txn_t q_d[$];

   ysyx_25040111_memarb #(.IDLE_RR(1'b1)) dut (
      .clock(clock), .reset(reset),
      .i_rstart(i_rstart), .i_raddr(i_raddr), .i_rlen(i_rlen),
      .i_rok(i_rok), .i_rdata(i_rdata),
      .d_start(d_start), .d_wen(d_wen), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_wmask(d_wmask), .d_ok(d_ok), .d_rdata(d_rdata),
      .m_start(m_start), .m_wen(m_wen), .m_addr(m_addr), .m_len(m_len),
      .m_wdata(m_wdata), .m_wmask(m_wmask), .m_ok(m_ok), .m_rdata(m_rdata)
   );

   always #5 clock = ~clock;

   initial begin
      #400000;
      $display("FAIL timeout: run did not reach its summary");
      $fatal(1, "timeout");
   end

   // Every D request in this bench uses a nonzero mask, I requests always carry 0
   always @(negedge clock) begin
      if (m_start) begin
         txn_t got;
         got = '{m_wen, m_addr, m_len, m_wdata, m_wmask};
         n_vec++;
         if (m_wmask != 4'd0) begin
            if (q_d.size() == 0) begin
               n_err++;
               $error("FAIL sb_d_unexpected observed=%h expected=none", got);
            end else begin
               txn_t e;
               e = q_d.pop_front();
               assert (got === e) else begin
                  n_err++;
                  $error("FAIL sb_d observed=%h expected=%h", got, e);
               end
            end
         end else begin
            if (q_i.size() == 0) begin
               n_err++;
               $error("FAIL sb_i_unexpected observed=%h expected=none", got);
            end else begin
               txn_t e;
               e = q_i.pop_front();
               assert (got === e) else begin
                  n_err++;
                  $error("FAIL sb_i observed=%h expected=%h", got, e);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      reset = 1'b1;
   endtask

   // One I start/beat pulse; the expected downstream beat carries burst length len
   task automatic i_beat(input logic [31:0] a, input logic [7:0] len);
      i_rstart = 1'b1;
      i_raddr  = a;
      i_rlen   = len;
      q_i.push_back('{1'b0, a, len, 32'd0, 4'd0});
      tick();
      i_rstart = 1'b0;
   endtask

   task automatic d_req(input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] wm, input bit expect_launch);
      d_start = 1'b1;
      d_wen   = w;
      d_addr  = a;
      d_wdata = wd;
      d_wmask = wm;
      if (expect_launch) q_d.push_back('{w, a, 8'd0, wd, wm});
   endtask

   task automatic ok_pulse(input logic ei, input logic ed, input logic [31:0] rd);
      m_ok    = 1'b1;
      m_rdata = rd;
      #1;
      chk1("i_rok", i_rok, ei);
      chk1("d_ok", d_ok, ed);
      if (ei) chk32("i_rdata", i_rdata, rd);
      if (ed) chk32("d_rdata", d_rdata, rd);
      tick();
      m_ok    = 1'b0;
      m_rdata = '0;
   endtask

   initial begin
      repeat (3) tick();
      reset = 1'b1;
      chk1("rst_m_start", m_start, 1'b0);
      chk1("rst_m_wen", m_wen, 1'b0);
      chk32("rst_m_addr", m_addr, 32'd0);
      chk32("rst_m_len", 32'(m_len), 32'd0);
      chk32("rst_m_wdata", m_wdata, 32'd0);
      chk32("rst_m_wmask", 32'(m_wmask), 32'd0);
      ok_pulse(1'b0, 1'b0, 32'hDEAD0000);

      // Lone I burst of four beats
      i_beat(32'h8000_0040, 8'd3);
      chk1("i1_m_start", m_start, 1'b1);
      chk32("i1_m_addr", m_addr, 32'h8000_0040);
      chk32("i1_m_len", 32'(m_len), 32'd3);
      ok_pulse(1'b1, 1'b0, 32'h1111_0000);
      chk1("i1_start_pulse", m_start, 1'b0);
      for (int k = 1; k < 4; k++) begin
         i_beat(32'h8000_0040 + 32'(4 * k), 8'd3);
         ok_pulse(1'b1, 1'b0, 32'h1111_0000 + 32'(k));
      end
      ok_pulse(1'b0, 1'b0, 32'h0BAD_0001);

      // Lone D write
      d_req(1'b1, 32'hA000_03F8, 32'h1234_5678, 4'hF, 1'b1);
      tick();
      d_start = 1'b0;
      chk1("d1_m_start", m_start, 1'b1);
      chk1("d1_m_wen", m_wen, 1'b1);
      chk32("d1_m_addr", m_addr, 32'hA000_03F8);
      chk32("d1_m_wdata", m_wdata, 32'h1234_5678);
      chk32("d1_m_len", 32'(m_len), 32'd0);
      ok_pulse(1'b0, 1'b1, 32'h2222_3333);
      ok_pulse(1'b0, 1'b0, 32'h0BAD_0002);

      // Tie right after reset: I first, D launches zero-bubble after I's last beat
      do_reset();
      i_rlen = 8'd3;
      d_req(1'b0, 32'hA000_1000, 32'h5555_AAAA, 4'h3, 1'b1);
      i_beat(32'h8000_0100, 8'd3);
      d_start = 1'b0;
      chk1("tie1_i_first", m_start, 1'b1);
      chk32("tie1_i_addr", m_addr, 32'h8000_0100);
      ok_pulse(1'b1, 1'b0, 32'h3000_0000);
      for (int k = 1; k < 4; k++) begin
         i_beat(32'h8000_0100 + 32'(4 * k), 8'd3);
         ok_pulse(1'b1, 1'b0, 32'h3000_0000 + 32'(k));
      end
      chk1("tie1_d_handover", m_start, 1'b1);
      chk32("tie1_d_addr", m_addr, 32'hA000_1000);
      ok_pulse(1'b0, 1'b1, 32'h3000_00DD);

      // After an I transaction the tie goes to D; I launches from its captured request
      i_beat(32'h8000_0200, 8'd0);
      ok_pulse(1'b1, 1'b0, 32'h4000_0000);
      d_req(1'b0, 32'hA000_2000, 32'h0, 4'h1, 1'b1);
      i_beat(32'h8000_0300, 8'd1);
      d_start = 1'b0;
      i_raddr = 32'hFFFF_FFF0;
      i_rlen  = 8'd7;
      chk1("tie2_d_first", m_start, 1'b1);
      chk32("tie2_d_addr", m_addr, 32'hA000_2000);
      ok_pulse(1'b0, 1'b1, 32'h4000_00DD);
      chk1("tie2_i_handover", m_start, 1'b1);
      chk32("tie2_i_addr", m_addr, 32'h8000_0300);
      chk32("tie2_i_len", 32'(m_len), 32'd1);
      ok_pulse(1'b1, 1'b0, 32'h4000_0001);
      i_beat(32'h8000_0304, 8'd1);
      ok_pulse(1'b1, 1'b0, 32'h4000_0002);

      // D request arriving mid I burst waits and keeps its captured fields
      i_beat(32'h8000_0400, 8'd3);
      ok_pulse(1'b1, 1'b0, 32'h5000_0000);
      i_beat(32'h8000_0404, 8'd3);
      d_req(1'b1, 32'hA000_3000, 32'hCAFE_F00D, 4'hC, 1'b1);
      tick();
      d_start = 1'b0;
      d_addr  = 32'h1357_9BDF;
      d_wdata = 32'h0;
      ok_pulse(1'b1, 1'b0, 32'h5000_0001);
      for (int k = 2; k < 4; k++) begin
         i_beat(32'h8000_0400 + 32'(4 * k), 8'd3);
         ok_pulse(1'b1, 1'b0, 32'h5000_0000 + 32'(k));
      end
      chk1("mid_d_handover", m_start, 1'b1);
      chk32("mid_d_addr", m_addr, 32'hA000_3000);
      chk32("mid_d_wdata", m_wdata, 32'hCAFE_F00D);
      ok_pulse(1'b0, 1'b1, 32'h5000_00DD);

      // Reset at beat 1 of 4 with D pending drops everything
      i_beat(32'h8000_0500, 8'd3);
      ok_pulse(1'b1, 1'b0, 32'h6000_0000);
      d_req(1'b0, 32'hA000_4000, 32'h0, 4'h8, 1'b0);
      tick();
      d_start = 1'b0;
      do_reset();
      chk1("mrst_m_start", m_start, 1'b0);
      chk32("mrst_m_addr", m_addr, 32'd0);
      chk32("mrst_m_len", 32'(m_len), 32'd0);
      chk32("mrst_m_wmask", 32'(m_wmask), 32'd0);
      ok_pulse(1'b0, 1'b0, 32'h0BAD_0003);
      for (int k = 0; k < 3; k++) begin
         chk1("mrst_no_launch", m_start, 1'b0);
         tick();
      end

      chk32("sb_i_drained", 32'(q_i.size()), 32'd0);
      chk32("sb_d_drained", 32'(q_d.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
